// File: rtl/tl_e_ack_scheduler.sv
// TileLink E-channel GrantAck scheduler: one registered E slot fed by NREQ requesters.
// Define TL_E_ACK_SCHED_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module tl_e_ack_scheduler #(
  parameter int NREQ   = 2,
  parameter int SINK_W = 1,
  localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*SINK_W-1:0]   req_sink,
  output logic [NREQ-1:0]          req_ready,
  output logic                     e_valid,
  input  logic                     e_ready,
  output logic [SINK_W-1:0]        e_sink,
  output logic [SRC_W-1:0]         e_src,
  output logic [15:0]              ack_count
);

  localparam logic [SRC_W:0] NREQ_W = (SRC_W+1)'(NREQ);

  logic              e_valid_q, e_valid_d;
  logic [SINK_W-1:0] e_sink_q, e_sink_d;
  logic [SRC_W-1:0]  e_src_q, e_src_d;
  logic [15:0]       ack_count_q, ack_count_d;
  logic [SRC_W-1:0]  rr_ptr_q;

  logic              slot_free;
  logic              accept;
  logic              grant_found;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W:0]    cand;
  logic [SINK_W-1:0] sink_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sink
      assign sink_arr[gi] = req_sink[gi*SINK_W +: SINK_W];
    end
  endgenerate

  // Search upward from the pointer, wrapping modulo NREQ; a zero pointer gives fixed priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!grant_found && req_valid[cand[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SRC_W-1:0];
      end
    end
  end

  assign slot_free = !e_valid_q || e_ready;

  always_comb begin
    req_ready = '0;
    if (!reset && grant_found && slot_free) req_ready[grant_idx] = 1'b1;
  end

  assign accept = |req_ready;

  always_comb begin
    e_valid_d   = e_valid_q;
    e_sink_d    = e_sink_q;
    e_src_d     = e_src_q;
    ack_count_d = ack_count_q;
    if (accept) begin
      e_valid_d = 1'b1;
      e_sink_d  = sink_arr[grant_idx];
      e_src_d   = grant_idx;
    end else if (e_valid_q && e_ready) begin
      e_valid_d = 1'b0;
    end
    if (e_valid_q && e_ready && ack_count_q != 16'hFFFF) ack_count_d = ack_count_q + 16'd1;
  end

`ifdef TL_E_ACK_SCHED_RR_EN
  logic [SRC_W-1:0] rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (grant_idx == SRC_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  assign rr_ptr_q = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      e_valid_q   <= 1'b0;
      e_sink_q    <= '0;
      e_src_q     <= '0;
      ack_count_q <= '0;
    end else begin
      e_valid_q   <= e_valid_d;
      e_sink_q    <= e_sink_d;
      e_src_q     <= e_src_d;
      ack_count_q <= ack_count_d;
    end
  end

  assign e_valid   = e_valid_q;
  assign e_sink    = e_sink_q;
  assign e_src     = e_src_q;
  assign ack_count = ack_count_q;

endmodule

// File: tb/tb_tl_e_ack_scheduler.sv
// Scoreboard bench for tl_e_ack_scheduler: directed scenarios plus randomized requesters/backpressure.
module tb_tl_e_ack_scheduler;
  localparam int NREQ   = 2;
  localparam int SINK_W = 1;
  localparam int SRC_W  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*SINK_W-1:0] req_sink;
  logic [NREQ-1:0]        req_ready;
  logic                   e_valid;
  logic                   e_ready;
  logic [SINK_W-1:0]      e_sink;
  logic [SRC_W-1:0]       e_src;
  logic [15:0]            ack_count;

  tl_e_ack_scheduler #(.NREQ(NREQ), .SINK_W(SINK_W)) dut (
    .clock    (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_sink (req_sink),
    .req_ready(req_ready),
    .e_valid  (e_valid),
    .e_ready  (e_ready),
    .e_sink   (e_sink),
    .e_src    (e_src),
    .ack_count(ack_count)
  );

  typedef struct packed {
    logic [SINK_W-1:0] sink;
    logic [SRC_W-1:0]  src;
  } beat_t;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];
  logic  known = 1'b0;
  logic  m_valid = 1'b0;
  int    m_rr = 0;
  logic [15:0] m_count = 16'd0;
  logic  exp_evalid = 1'b0;
  logic [NREQ-1:0] got_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference arbitration: first valid requester at or after the pointer, modulo NREQ.
  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
`ifdef TL_E_ACK_SCHED_RR_EN
      int idx = (m_rr + k) % NREQ;
`else
      int idx = k;
`endif
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*SINK_W-1:0] s,
                      input logic er, input logic rst);
    logic [NREQ-1:0] exp_ready;
    int    w;
    logic  drain;
    beat_t b;
    @(negedge clk);
    reset     = rst;
    req_valid = v;
    req_sink  = s;
    e_ready   = er;
    #1;
    exp_ready = '0;
    w = -1;
    if (!rst && known && (!m_valid || er)) w = pick(v);
    if (w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (known) chk("ack_count", 32'(ack_count), 32'(m_count));
    got_ready  = req_ready;
    exp_evalid = m_valid;
    if (rst) begin
      m_valid = 1'b0;
      m_count = 16'd0;
      m_rr    = 0;
      exp_q.delete();
      known   = 1'b1;
    end else begin
      drain = m_valid && er;
      if (drain && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (w >= 0) begin
        b.sink = s[w*SINK_W +: SINK_W];
        b.src  = SRC_W'(w);
        exp_q.push_back(b);
        m_rr    = (w + 1) % NREQ;
        m_valid = 1'b1;
      end else if (drain) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Monitor: checks the presented beat against the scoreboard and retires it on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (known && !reset) begin
        chk("e_valid", 32'(e_valid), 32'(exp_evalid));
        if (exp_evalid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got beat src=%0d expected none", e_src);
          end else begin
            chk("e_sink", 32'(e_sink), 32'(exp_q[0].sink));
            chk("e_src", 32'(e_src), 32'(exp_q[0].src));
            if (e_ready) begin
              $display("ack beat src=%0d sink=%0h t=%0t", e_src, e_sink, $time);
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    logic [NREQ-1:0]        pend;
    logic [NREQ*SINK_W-1:0] psink;
    logic                   rst_now;
    logic [NREQ-1:0]        fair_exp;

    reset = 1'b1; req_valid = '0; req_sink = '0; e_ready = 1'b0;

    // Reset with both requesters asking
    step(2'b11, 2'b00, 1'b1, 1'b1);
    step(2'b11, 2'b00, 1'b1, 1'b1);
    chk("reset_e_valid", 32'(e_valid), 32'd0);
    step(2'b00, 2'b00, 1'b1, 1'b0);

    // Single ack from requester 0 with sink 1
    step(2'b01, 2'b01, 1'b1, 1'b0);
    chk("single_ready", 32'(got_ready), 32'h1);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    chk("single_count", 32'(ack_count), 32'd1);

    // Backpressure: requester 1 beat held 5 cycles while requester 0 waits
    step(2'b10, 2'b10, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b1, 1'b0);
    chk("bp_refill_ready", 32'(got_ready), 32'h1);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b0);

    // Fairness / fixed priority with both valid for 6 cycles
    step(2'b00, 2'b00, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(2'b11, NREQ*SINK_W'($urandom), 1'b1, 1'b0);
`ifdef TL_E_ACK_SCHED_RR_EN
      fair_exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      fair_exp = 2'b01;
`endif
      chk("fair_grant", 32'(got_ready), 32'(fair_exp));
    end
    step(2'b00, 2'b00, 1'b1, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    chk("fair_count", 32'(ack_count), 32'd6);

    // Randomized requesters, backpressure and occasional reset
    pend = '0; psink = '0;
    for (int c = 0; c < 600; c++) begin
      rst_now = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          psink[i*SINK_W +: SINK_W] = SINK_W'($urandom);
        end
      end
      step(pend, psink, ($urandom_range(0, 3) != 0), rst_now);
      if (rst_now) pend = '0;
      else         pend = pend & ~got_ready;
    end
    for (int k = 0; k < 3; k++) step(2'b00, 2'b00, 1'b1, 1'b0);

    // Saturation: preload FFFE, then three accepted beats
    force dut.ack_count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    step(2'b00, 2'b00, 1'b1, 1'b0);
    release dut.ack_count_q;
    for (int k = 0; k < 3; k++) step(2'b01, 2'b00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 2'b00, 1'b1, 1'b0);
      chk("sat_count", 32'(ack_count), 32'hFFFF);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
